// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared data-memory geometry and arbiter state encoding
package dmem_arbiter_pkg;

    localparam int DATA_MEM_ADDRESS = 8;
    localparam int DATA_MEM_LENGTH  = 1 << DATA_MEM_ADDRESS;

    typedef enum logic {
        S_ARB   = 1'b0,
        S_LOCK1 = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter for the single-port data memory
// Optional starvation guard for port 1 enabled by defining DMEM_ARB_STARVE_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DATA_MEM_ADDRESS,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [31:0]       p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    input  logic              p1_lock,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [31:0]       p1_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT >= (1 << CNT_W)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for STARVE_LIMIT");
    end

    arb_state_t state;
    logic       starve_force;

`ifdef DMEM_ARB_STARVE_EN
    logic [CNT_W-1:0] starve_cnt;

    assign starve_force = (starve_cnt == CNT_W'(STARVE_LIMIT)) && p0_req && p1_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (p1_gnt || !p1_req) begin
            starve_cnt <= '0;
        end else if (p0_gnt && starve_cnt != CNT_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign starve_force = 1'b0;
`endif

    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (state == S_LOCK1) begin
            p1_gnt = p1_req;
            p0_gnt = p0_req && !p1_req;
        end else begin
            p0_gnt = p0_req && !starve_force;
            p1_gnt = p1_req && (!p0_req || starve_force);
        end
    end

    // Idle cycles park the bus on port 0 with the write strobe low.
    assign mem_address    = p1_gnt ? p1_addr  : p0_addr;
    assign mem_write_data = p1_gnt ? p1_wdata : p0_wdata;
    assign mem_wen        = rst_n && ((p0_gnt && p0_we) || (p1_gnt && p1_we));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_ARB;
        end else begin
            case (state)
                S_ARB:   if (p1_gnt && p1_lock) state <= S_LOCK1;
                S_LOCK1: if (!(p1_req && p1_lock)) state <= S_ARB;
                default: state <= S_ARB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= 32'h0;
            p1_rdata  <= 32'h0;
        end else begin
            p0_rvalid <= p0_gnt && !p0_we;
            p1_rvalid <= p1_gnt && !p1_we;
            if (p0_gnt && !p0_we) p0_rdata <= mem_read_data;
            if (p1_gnt && !p1_we) p1_rdata <= mem_read_data;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter with a behavioural data memory
module tb_dmem_arbiter;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [AW-1:0] p0_addr;
    logic [31:0]   p0_wdata, p0_rdata;
    logic          p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
    logic [AW-1:0] p1_addr;
    logic [31:0]   p1_wdata, p1_rdata;
    logic          mem_wen;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_write_data, mem_read_data;

    logic [31:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_wen) mem[mem_address] <= mem_write_data;
    assign mem_read_data = mem[mem_address];

    dmem_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_wen(mem_wen), .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p0_req = 0; p0_we = 0; p1_req = 0; p1_we = 0; p1_lock = 0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA000_0000 + i;
        rst_n = 0;
        idle();
        p0_addr = '0; p0_wdata = '0; p1_addr = '0; p1_wdata = '0;

        // reset state; grant still follows request
        #12;
        p0_req = 1;
        #1;
        check("rst_p0_rvalid", {31'b0, p0_rvalid}, 0);
        check("rst_p1_rvalid", {31'b0, p1_rvalid}, 0);
        check("rst_p0_rdata", p0_rdata, 32'h0);
        check("rst_p1_rdata", p1_rdata, 32'h0);
        check("rst_p0_gnt_follows_req", {31'b0, p0_gnt}, 1);
        p0_req = 0;
        tick();
        rst_n = 1;
        tick();

        // 1: write then read-back on port 0
        p0_req = 1; p0_we = 1; p0_addr = 8'h10; p0_wdata = 32'hDEADBEEF;
        #1;
        check("t1_wr_gnt", {31'b0, p0_gnt}, 1);
        check("t1_wr_wen", {31'b0, mem_wen}, 1);
        tick();
        check("t1_wr_no_rvalid", {31'b0, p0_rvalid}, 0);
        p0_we = 0;
        #1;
        check("t1_rd_gnt", {31'b0, p0_gnt}, 1);
        check("t1_rd_wen", {31'b0, mem_wen}, 0);
        tick();
        check("t1_rvalid", {31'b0, p0_rvalid}, 1);
        check("t1_rdata", p0_rdata, 32'hDEADBEEF);
        idle();
        tick();
        check("t1_rvalid_drop", {31'b0, p0_rvalid}, 0);
        check("t1_rdata_hold", p0_rdata, 32'hDEADBEEF);

        // 2: simultaneous reads, port 0 first
        p0_req = 1; p0_addr = 8'h10; p1_req = 1; p1_addr = 8'h30;
        #1;
        check("t2_p0_gnt", {31'b0, p0_gnt}, 1);
        check("t2_p1_wait", {31'b0, p1_gnt}, 0);
        check("t2_addr_p0", {24'b0, mem_address}, 32'h10);
        tick();
        p0_req = 0;
        #1;
        check("t2_p1_gnt", {31'b0, p1_gnt}, 1);
        check("t2_addr_p1", {24'b0, mem_address}, 32'h30);
        check("t2_p0_rdata", p0_rdata, 32'hDEADBEEF);
        tick();
        p1_req = 0;
        check("t2_p1_rvalid", {31'b0, p1_rvalid}, 1);
        check("t2_p1_rdata", p1_rdata, 32'hA0000030);
        check("t2_p0_rvalid_low", {31'b0, p0_rvalid}, 0);
        tick();

        // 3: locked 4-beat write burst from port 1 holds off port 0
        p1_req = 1; p1_we = 1; p1_lock = 1;
        for (int b = 0; b < 4; b++) begin
            p1_addr = 8'h20 + 8'(b);
            p1_wdata = 32'h1111_0020 + b;
            if (b == 3) p1_lock = 0;
            #1;
            check($sformatf("t3_p1_gnt_%0d", b), {31'b0, p1_gnt}, 1);
            check($sformatf("t3_p0_held_%0d", b), {31'b0, p0_gnt}, 0);
            check($sformatf("t3_wen_%0d", b), {31'b0, mem_wen}, 1);
            tick();
            if (b == 0) begin p0_req = 1; p0_we = 0; p0_addr = 8'h23; end
        end
        p1_req = 0; p1_we = 0;
        #1;
        check("t3_p0_after", {31'b0, p0_gnt}, 1);
        tick();
        check("t3_p0_rdata", p0_rdata, 32'h11110023);
        idle();
        tick();

        // 4: both ports requesting continuously
        p0_req = 1; p0_addr = 8'h01; p1_req = 1; p1_addr = 8'h02;
        for (int c = 0; c < 10; c++) begin
            #1;
`ifdef DMEM_ARB_STARVE_EN
            check($sformatf("t4_p1_gnt_%0d", c), {31'b0, p1_gnt}, (c % 5 == 4) ? 1 : 0);
            check($sformatf("t4_p0_gnt_%0d", c), {31'b0, p0_gnt}, (c % 5 == 4) ? 0 : 1);
`else
            check($sformatf("t4_p1_gnt_%0d", c), {31'b0, p1_gnt}, 0);
            check($sformatf("t4_p0_gnt_%0d", c), {31'b0, p0_gnt}, 1);
`endif
            tick();
        end
        idle();
        tick();

        // 5: reset in the middle of a locked burst
        p1_req = 1; p1_lock = 1; p1_we = 0; p1_addr = 8'h28;
        tick();
        check("t5_p1_rvalid_pre", {31'b0, p1_rvalid}, 1);
        p1_we = 1; p1_addr = 8'h29; p1_wdata = 32'h0000_0BAD; p0_req = 1; p0_addr = 8'h29;
        rst_n = 0;
        #1;
        check("t5_rvalid_cleared", {31'b0, p1_rvalid}, 0);
        check("t5_no_wen", {31'b0, mem_wen}, 0);
        tick();
        rst_n = 1;
        #1;
        check("t5_p0_first", {31'b0, p0_gnt}, 1);
        check("t5_p1_waits", {31'b0, p1_gnt}, 0);
        idle();
        p0_req = 1;
        tick();
        check("t5_no_write_leak", p0_rdata, 32'hA0000029);
        idle();
        tick();

        // 6: lock held but request dropped -> back to S_ARB
        p1_req = 1; p1_lock = 1; p1_we = 0; p1_addr = 8'h2A;
        tick();
        p1_req = 0;
        #1;
        check("t6_no_p1_gnt", {31'b0, p1_gnt}, 0);
        check("t6_no_wen", {31'b0, mem_wen}, 0);
        tick();
        p1_req = 1; p1_lock = 0; p0_req = 1; p0_addr = 8'h05;
        #1;
        check("t6_arb_p0_wins", {31'b0, p0_gnt}, 1);
        check("t6_arb_p1_waits", {31'b0, p1_gnt}, 0);
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
